// File: rtl/updown_counter_disp.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_disp
//  Purpose  : Parametrised up/down counter with synchronous load, wrap or
//             saturate behaviour at the limits and a one-cycle terminal-count
//             pulse. The count is shown in hex on a multiplexed multi-digit
//             7-segment display.
//  Ports    : CLK      - system clock, rising edge
//             RESET    - synchronous active-high reset
//             EN       - count enable, one step per cycle while high
//             UP       - direction, 1 = increment, 0 = decrement
//             LOAD     - synchronous load of LOAD_VAL (beats EN)
//             LOAD_VAL - value to load
//             OUT      - registered count
//             TC       - one-cycle pulse when a step wrapped or was blocked
//             SEGMENT  - registered segments, bit0 = a ... bit6 = g
//             DIGIT    - registered one-hot digit select, bit0 = low nibble
//  Revision : 1.0  initial release
// ============================================================================
module updown_counter_disp #(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 2,
    parameter int SATURATE       = 0,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              UP,
    input  logic              LOAD,
    input  logic [WIDTH-1:0]  LOAD_VAL,
    output logic [WIDTH-1:0]  OUT,
    output logic              TC,
    output logic [6:0]        SEGMENT,
    output logic [DIGITS-1:0] DIGIT
);

    // Counter widths; a one-value range still needs a one-bit register.
    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w  = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int c_pad_w  = 4 * DIGITS;

    localparam logic              c_invert    = (SEG_ACTIVE_LOW != 0);
    localparam logic              c_saturate  = (SATURATE != 0);
    localparam logic [6:0]        c_seg_zero  = 7'h3F;
    localparam logic [DIGITS-1:0] c_dig_first = DIGITS'(1);

    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DIGITS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    r_out;
    logic                r_tc;
    logic [c_scan_w-1:0] r_scan;
    logic [c_idx_w-1:0]  r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_digit;

    // ------------------------------------------------------------------------
    // Counter next-state
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tc_nxt;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = &r_out;
    assign w_at_min = (r_out == '0);

    always_comb begin
        w_out_nxt = r_out;
        w_tc_nxt  = 1'b0;
        if (LOAD) begin
            w_out_nxt = LOAD_VAL;
        end else if (EN) begin
            if (UP) begin
                if (w_at_max) begin
                    // Limit step: flag it, then either wrap or stay put.
                    w_tc_nxt  = 1'b1;
                    w_out_nxt = c_saturate ? r_out : '0;
                end else begin
                    w_out_nxt = r_out + WIDTH'(1);
                end
            end else begin
                if (w_at_min) begin
                    w_tc_nxt  = 1'b1;
                    w_out_nxt = c_saturate ? r_out : '1;
                end else begin
                    w_out_nxt = r_out - WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display scan: free-running prescaler advances the digit index
    // ------------------------------------------------------------------------
    logic                w_scan_wrap;
    logic [c_scan_w-1:0] w_scan_nxt;
    logic [c_idx_w-1:0]  w_idx_nxt;

    assign w_scan_wrap = (r_scan == c_scan_last);
    assign w_scan_nxt  = w_scan_wrap ? '0 : r_scan + c_scan_w'(1);

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_scan_wrap) begin
            w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Digit select and nibble pick. The display register is loaded with the
    // digit that the index moves to on this edge, so DIGIT always matches the
    // index and the nibble comes from the count held before this edge.
    // ------------------------------------------------------------------------
    logic [c_pad_w-1:0] w_out_pad;
    logic [3:0]         w_nib;
    logic [DIGITS-1:0]  w_digit_raw;

    // Zero-extension makes digits above WIDTH read as 0.
    assign w_out_pad = c_pad_w'(r_out);

    always_comb begin
        w_nib       = 4'h0;
        w_digit_raw = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == c_idx_w'(i)) begin
                w_nib          = w_out_pad[4*i +: 4];
                w_digit_raw[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hex to 7-segment, gfedcba, active-high
    // ------------------------------------------------------------------------
    logic [6:0] w_seg_raw;

    always_comb begin
        w_seg_raw = 7'h00;
        case (w_nib)
            4'h0: w_seg_raw = 7'h3F;
            4'h1: w_seg_raw = 7'h06;
            4'h2: w_seg_raw = 7'h5B;
            4'h3: w_seg_raw = 7'h4F;
            4'h4: w_seg_raw = 7'h66;
            4'h5: w_seg_raw = 7'h6D;
            4'h6: w_seg_raw = 7'h7D;
            4'h7: w_seg_raw = 7'h07;
            4'h8: w_seg_raw = 7'h7F;
            4'h9: w_seg_raw = 7'h6F;
            4'hA: w_seg_raw = 7'h77;
            4'hB: w_seg_raw = 7'h7C;
            4'hC: w_seg_raw = 7'h39;
            4'hD: w_seg_raw = 7'h5E;
            4'hE: w_seg_raw = 7'h79;
            4'hF: w_seg_raw = 7'h71;
            default: w_seg_raw = 7'h00;
        endcase
    end

    // Common-anode boards want both buses inverted; done before the register
    // so the pins come straight from flops.
    logic [6:0]        w_seg_pin;
    logic [DIGITS-1:0] w_digit_pin;

    assign w_seg_pin   = c_invert ? ~w_seg_raw   : w_seg_raw;
    assign w_digit_pin = c_invert ? ~w_digit_raw : w_digit_raw;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out   <= '0;
            r_tc    <= 1'b0;
            r_scan  <= '0;
            r_idx   <= '0;
            r_seg   <= c_invert ? ~c_seg_zero  : c_seg_zero;
            r_digit <= c_invert ? ~c_dig_first : c_dig_first;
        end else begin
            r_out   <= w_out_nxt;
            r_tc    <= w_tc_nxt;
            r_scan  <= w_scan_nxt;
            r_idx   <= w_idx_nxt;
            r_seg   <= w_seg_pin;
            r_digit <= w_digit_pin;
        end
    end

    assign OUT     = r_out;
    assign TC      = r_tc;
    assign SEGMENT = r_seg;
    assign DIGIT   = r_digit;

endmodule
`default_nettype wire
